// File: rtl/cu_param.sv
// Parametrised multi-cycle control unit: fetches variable-length instructions from
// program memory, drives an external combinational ALU and a req/ack data memory.
module cu_param #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int NUM_GPR = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pm_addr,
    input  logic [DATA_W-1:0] pm_data,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_wdata,
    input  logic [DATA_W-1:0] dm_rdata,
    input  logic              dm_ack,
    output logic [7:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg
);

    localparam int RIDX_W = $clog2(NUM_GPR);
    localparam int BIT_W  = $clog2(DATA_W);

    localparam logic [7:0] OP_NOP   = 8'h00, OP_ADD = 8'h01, OP_SUB = 8'h02, OP_MOVRR = 8'h03;
    localparam logic [7:0] OP_MOVRA = 8'h04, OP_MOVAR = 8'h05, OP_MOVIR = 8'h06, OP_JMP = 8'h07;
    localparam logic [7:0] OP_JB    = 8'h08, OP_JNB = 8'h09, OP_JZ = 8'h0C, OP_JNZ = 8'h0D;
    localparam logic [7:0] OP_CPL   = 8'h0E, OP_AND = 8'h0F, OP_OR = 8'h10, OP_XOR = 8'h11;
    localparam logic [7:0] OP_CLR   = 8'h12, OP_RSH = 8'h13, OP_LSH = 8'h14;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_OP1, S_OP2, S_MEM, S_WB, S_HALT
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [7:0]          ir_q;
    logic [DATA_W-1:0]   op1_q;
    logic [RIDX_W-1:0]   dst_q;
    logic                dm_req_q, dm_we_q, halted_q;
    logic [ADDR_W-1:0]   dm_addr_q;
    logic [DATA_W-1:0]   dm_wdata_q;
    logic [7:0]          alu_op_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;

    logic [NUM_GPR-1:0][DATA_W-1:0] rf_rd;
    logic                rf_we;
    logic [RIDX_W-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;

    logic [7:0]          opcode;
    logic [ADDR_W-1:0]   pc_inc, pm_target;
    logic                is_legal, is_binary, is_unary, is_cjump, cjump_taken;
    logic [DATA_W-1:0]   rd_pm_reg, rd_pm_src, rd_op1;
    logic                cond_bit;

    assign opcode    = ir_q;
    assign pc_inc    = pc_q + ADDR_W'(1);
    assign pm_target = pm_data[ADDR_W-1:0];
    assign rd_pm_reg = rf_rd[pm_data[RIDX_W-1:0]];
    assign rd_pm_src = rf_rd[pm_data[4 +: RIDX_W]];
    assign rd_op1    = rf_rd[op1_q[RIDX_W-1:0]];
    assign cond_bit  = rd_op1[op1_q[4 +: BIT_W]];

    always_comb begin
        is_legal  = (opcode <= OP_JNB) || ((opcode >= OP_JZ) && (opcode <= OP_LSH));
        is_binary = opcode inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
        is_unary  = opcode inside {OP_CPL, OP_RSH, OP_LSH};
        is_cjump  = opcode inside {OP_JB, OP_JNB, OP_JZ, OP_JNZ};
        case (opcode)
            OP_JB:   cjump_taken = cond_bit;
            OP_JNB:  cjump_taken = !cond_bit;
            OP_JZ:   cjump_taken = (rd_op1 == '0);
            OP_JNZ:  cjump_taken = (rd_op1 != '0);
            default: cjump_taken = 1'b0;
        endcase
    end

    // Every register-file write in the machine funnels through this single port.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        case (state_q)
            S_DECODE: rf_we = (opcode == OP_CLR);
            S_OP1: if (opcode == OP_MOVRR) begin
                rf_we    = 1'b1;
                rf_waddr = pm_data[RIDX_W-1:0];
                rf_wdata = rd_pm_src;
            end
            S_OP2: if (opcode == OP_MOVIR) begin
                rf_we    = 1'b1;
                rf_waddr = pm_data[RIDX_W-1:0];
                rf_wdata = op1_q;
            end
            S_MEM: if (dm_ack && !dm_we_q) begin
                rf_we    = 1'b1;
                rf_waddr = dst_q;
                rf_wdata = dm_rdata;
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_wdata = alu_result;
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < NUM_GPR; gi++) begin : g_rf
        logic [DATA_W-1:0] r_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
            end else if (rf_we && (rf_waddr == RIDX_W'(gi))) begin
                r_q <= rf_wdata;
            end
        end
        assign rf_rd[gi] = r_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            op1_q      <= '0;
            dst_q      <= '0;
            dm_req_q   <= 1'b0;
            dm_we_q    <= 1'b0;
            dm_addr_q  <= '0;
            dm_wdata_q <= '0;
            alu_op_q   <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    ir_q    <= pm_data[7:0];
                    pc_q    <= pc_inc;
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    if (!is_legal) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else if ((opcode == OP_NOP) || (opcode == OP_CLR)) begin
                        state_q <= S_FETCH;
                    end else if (is_unary) begin
                        alu_op_q <= opcode;
                        alu_a_q  <= rf_rd[0];
                        alu_b_q  <= '0;
                        state_q  <= S_WB;
                    end else begin
                        state_q <= S_OP1;
                    end
                end
                S_OP1: begin
                    op1_q   <= pm_data;
                    pc_q    <= pc_inc;
                    state_q <= S_OP2;
                    if (opcode == OP_MOVRR) begin
                        state_q <= S_FETCH;
                    end else if (opcode == OP_JMP) begin
                        pc_q    <= pm_target;
                        state_q <= S_FETCH;
                    end else if (is_binary) begin
                        alu_op_q <= opcode;
                        alu_a_q  <= rf_rd[0];
                        alu_b_q  <= rd_pm_reg;
                        state_q  <= S_WB;
                    end
                end
                S_OP2: begin
                    pc_q    <= (is_cjump && cjump_taken) ? pm_target : pc_inc;
                    state_q <= S_FETCH;
                    if ((opcode == OP_MOVRA) || (opcode == OP_MOVAR)) begin
                        dm_req_q   <= 1'b1;
                        dm_we_q    <= (opcode == OP_MOVRA);
                        dm_addr_q  <= (opcode == OP_MOVRA) ? pm_target : op1_q[ADDR_W-1:0];
                        dm_wdata_q <= (opcode == OP_MOVRA) ? rd_op1 : '0;
                        dst_q      <= pm_data[RIDX_W-1:0];
                        state_q    <= S_MEM;
                    end
                end
                S_MEM: begin
                    if (dm_ack) begin
                        dm_req_q <= 1'b0;
                        state_q  <= S_FETCH;
                    end
                end
                S_WB:    state_q <= S_FETCH;
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_FETCH;
            endcase
        end
    end

    assign pm_addr  = pc_q;
    assign pc_dbg   = pc_q;
    assign dm_req   = dm_req_q;
    assign dm_we    = dm_we_q;
    assign dm_addr  = dm_addr_q;
    assign dm_wdata = dm_wdata_q;
    assign alu_op   = alu_op_q;
    assign alu_a    = alu_a_q;
    assign alu_b    = alu_b_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_cu_param.sv
// Bench for cu_param (16-bit data, 8 registers): an instruction-level interpreter
// predicts memory transactions and halt timing; monitors compare what the core does.
module tb_cu_param;

    localparam int DW = 16;
    localparam int AW = 8;
    localparam int NG = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW-1:0] pm_addr;
    logic [DW-1:0] pm_data;
    logic          dm_req, dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_ack;
    logic [7:0]    alu_op;
    logic [DW-1:0] alu_a, alu_b, alu_result;
    logic          halted;
    logic [AW-1:0] pc_dbg;

    always #5 clk = ~clk;

    cu_param #(.DATA_W(DW), .ADDR_W(AW), .NUM_GPR(NG)) dut (
        .clk(clk), .rst(rst), .pm_addr(pm_addr), .pm_data(pm_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack), .alu_op(alu_op), .alu_a(alu_a),
        .alu_b(alu_b), .alu_result(alu_result), .halted(halted), .pc_dbg(pc_dbg)
    );

    typedef struct packed { logic we; logic [7:0] addr; logic [15:0] data; } mem_t;
    typedef struct packed { int cyc; logic [7:0] pc; } halt_t;

    logic [15:0] pm_mem [256];
    logic [15:0] dm_mem [256];
    logic [15:0] m_dm   [256];
    mem_t        exp_mem_q [$];
    int          delay_q   [$];
    halt_t       exp_halt_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          wp;
    logic [7:0]  m_halt_pc;

    function automatic logic [15:0] alu_f(input logic [7:0] op, input logic [15:0] a, b);
        case (op)
            8'h01: return a + b;
            8'h02: return a - b;
            8'h0E: return ~a;
            8'h0F: return a & b;
            8'h10: return a | b;
            8'h11: return a ^ b;
            8'h13: return a >> 1;
            8'h14: return a << 1;
            default: return '0;
        endcase
    endfunction

    assign pm_data    = pm_mem[pm_addr];
    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    function automatic logic [15:0] rw(input logic [7:0] lo);
        return {8'($urandom), lo};
    endfunction

    task automatic emit(input logic [15:0] w);
        pm_mem[wp[7:0]] = w;
        wp++;
    endtask

    task automatic pm_clear();
        for (int i = 0; i < 256; i++) pm_mem[i] = 16'h000A;
        wp = 0;
    endtask

    // Store every register to 0xE0+i so the final register file becomes observable.
    task automatic dump();
        for (int i = 0; i < NG; i++) begin
            emit(rw(8'h04));
            emit(rw(8'(i)));
            emit(rw(8'hE0 + 8'(i)));
        end
        emit(16'h000A);
    endtask

    // Instruction-level reference: executes pm_mem from address 0 until an illegal opcode.
    task automatic model_run(input int fixed_delay);
        logic [15:0] r [8];
        logic [7:0]  pc, p1, p2, op;
        logic [15:0] w1, w2, sel;
        int          cycles, d;
        bit          done, taken;
        for (int i = 0; i < 8; i++) r[i] = '0;
        pc = '0; cycles = 0; done = 0;
        for (int step = 0; step < 3000 && !done; step++) begin
            p1 = pc + 8'd1; p2 = pc + 8'd2;
            op = pm_mem[pc][7:0]; w1 = pm_mem[p1]; w2 = pm_mem[p2];
            d  = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
            case (op)
                8'h00: begin pc = p1; cycles += 2; end
                8'h12: begin r[0] = '0; pc = p1; cycles += 2; end
                8'h0E, 8'h13, 8'h14: begin r[0] = alu_f(op, r[0], '0); pc = p1; cycles += 3; end
                8'h03: begin r[w1[2:0]] = r[w1[6:4]]; pc = p2; cycles += 3; end
                8'h07: begin pc = w1[7:0]; cycles += 3; end
                8'h01, 8'h02, 8'h0F, 8'h10, 8'h11: begin
                    r[0] = alu_f(op, r[0], r[w1[2:0]]); pc = p2; cycles += 4;
                end
                8'h06: begin r[w2[2:0]] = w1; pc = pc + 8'd3; cycles += 4; end
                8'h08, 8'h09, 8'h0C, 8'h0D: begin
                    sel = r[w1[2:0]];
                    case (op)
                        8'h08:   taken = sel[w1[7:4]];
                        8'h09:   taken = !sel[w1[7:4]];
                        8'h0C:   taken = (sel == 0);
                        default: taken = (sel != 0);
                    endcase
                    pc = taken ? w2[7:0] : pc + 8'd3; cycles += 4;
                end
                8'h04: begin
                    exp_mem_q.push_back('{1'b1, w2[7:0], r[w1[2:0]]});
                    m_dm[w2[7:0]] = r[w1[2:0]];
                    delay_q.push_back(d); pc = pc + 8'd3; cycles += 5 + d;
                end
                8'h05: begin
                    exp_mem_q.push_back('{1'b0, w1[7:0], 16'h0});
                    r[w2[2:0]] = m_dm[w1[7:0]];
                    delay_q.push_back(d); pc = pc + 8'd3; cycles += 5 + d;
                end
                default: begin
                    m_halt_pc = p1;
                    exp_halt_q.push_back('{cycles + 2, p1});
                    done = 1;
                end
            endcase
        end
        if (!done) fail("model_bound");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_pc", pc_dbg, 0);
        check("rst_pm_addr", pm_addr, 0);
        check("rst_dm", {dm_req, dm_we, dm_addr, dm_wdata}, 0);
        check("rst_alu", {alu_op, alu_a, alu_b}, 0);
        check("rst_halted", halted, 0);
        rst = 1'b0;
    endtask

    task automatic run_prog(input string name, input int fixed_delay);
        int n;
        exp_mem_q.delete(); delay_q.delete(); exp_halt_q.delete();
        for (int i = 0; i < 256; i++) begin
            dm_mem[i] = 16'($urandom);
            m_dm[i]   = dm_mem[i];
        end
        model_run(fixed_delay);
        do_reset();
        n = 0;
        while (!halted && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!halted) fail({name, "_halt_timeout"});
        repeat (10) @(negedge clk);
        check({name, "_pc_frozen"}, pc_dbg, m_halt_pc);
        check({name, "_still_halted"}, halted, 1);
        check({name, "_mem_pending"}, exp_mem_q.size(), 0);
        check({name, "_halt_seen"}, exp_halt_q.size(), 0);
        $display("run %s: halted at pc=%02h after %0d cycles", name, pc_dbg, cyc);
    endtask

    // Data-memory responder and transaction monitor.
    initial begin
        bit          busy, acking, stable;
        int          wcnt;
        mem_t        e;
        logic        cap_we;
        logic [7:0]  cap_addr;
        logic [15:0] cap_wdata;
        busy = 0; acking = 0; stable = 0; wcnt = 0;
        dm_ack = 1'b0; dm_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy = 0; acking = 0; dm_ack = 1'b0;
            end else begin
                if (busy && acking) begin
                    busy = 0; acking = 0;
                end
                if (!busy && dm_req) begin
                    busy = 1; stable = 1;
                    cap_we = dm_we; cap_addr = dm_addr; cap_wdata = dm_wdata;
                    if (delay_q.size() > 0) wcnt = delay_q.pop_front();
                    else wcnt = 0;
                    $display("mem %s addr=%02h wdata=%04h delay=%0d", dm_we ? "wr" : "rd",
                             dm_addr, dm_wdata, wcnt);
                    if (exp_mem_q.size() == 0) begin
                        fail("dm_unexpected_req");
                    end else begin
                        e = exp_mem_q.pop_front();
                        check("dm_we", dm_we, e.we);
                        check("dm_addr", dm_addr, e.addr);
                        if (e.we) check("dm_wdata", dm_wdata, e.data);
                    end
                end
                if (busy) begin
                    if (!dm_req || dm_we !== cap_we || dm_addr !== cap_addr || dm_wdata !== cap_wdata)
                        stable = 0;
                    if (wcnt == 0) begin
                        dm_ack = 1'b1; acking = 1;
                        if (dm_we) dm_mem[dm_addr] = dm_wdata;
                        dm_rdata = dm_we ? 16'($urandom) : dm_mem[dm_addr];
                        check("dm_hold", stable, 1'b1);
                    end else begin
                        dm_ack = 1'b0; dm_rdata = 16'($urandom); wcnt--;
                    end
                end else begin
                    dm_ack   = ($urandom_range(0, 3) == 0);
                    dm_rdata = 16'($urandom);
                end
            end
        end
    end

    // Halt monitor: timing of the halted rise and the frozen pc.
    initial begin
        bit    prev;
        halt_t h;
        prev = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 0;
            end else begin
                if (halted && !prev) begin
                    $display("halt pc=%02h cycle=%0d", pc_dbg, cyc);
                    if (exp_halt_q.size() == 0) begin
                        fail("halt_unexpected");
                    end else begin
                        h = exp_halt_q.pop_front();
                        check("halt_cycle", cyc, h.cyc);
                        check("halt_pc", pc_dbg, h.pc);
                    end
                end
                prev = halted;
            end
        end
    end

    task automatic gen_random();
        logic [7:0] ops1 [5] = '{8'h00, 8'h12, 8'h0E, 8'h13, 8'h14};
        logic [7:0] opsb [5] = '{8'h01, 8'h02, 8'h0F, 8'h10, 8'h11};
        logic [7:0] opsj [4] = '{8'h08, 8'h09, 8'h0C, 8'h0D};
        pm_clear();
        while (wp < 8'hC0) begin
            case ($urandom_range(0, 8))
                0: emit(rw(ops1[$urandom_range(0, 4)]));
                1: begin emit(rw(opsb[$urandom_range(0, 4)])); emit(rw(8'($urandom))); end
                2: begin emit(rw(8'h03)); emit(rw(8'($urandom))); end
                3, 4: begin emit(rw(8'h06)); emit(16'($urandom)); emit(rw(8'($urandom))); end
                5: begin emit(rw(8'h04)); emit(rw(8'($urandom))); emit(rw(8'($urandom))); end
                6: begin emit(rw(8'h05)); emit(rw(8'($urandom))); emit(rw(8'($urandom))); end
                7: begin
                    emit(rw(opsj[$urandom_range(0, 3)])); emit(rw(8'($urandom)));
                    emit(rw(8'(wp + 2))); emit(rw(ops1[$urandom_range(1, 4)]));
                end
                default: begin
                    emit(rw(8'h07)); emit(rw(8'(wp + 2))); emit(rw(ops1[$urandom_range(1, 4)]));
                end
            endcase
        end
        dump();
    endtask

    initial begin
        int          n;
        logic [7:0]  bad [5] = '{8'h0A, 8'h0B, 8'h15, 8'hFF, 8'h80};
        dm_ack = 1'b0;

        pm_clear(); emit(16'h0000); emit(16'h0000);
        run_prog("nop", 0);

        pm_clear();
        emit(16'h0006); emit(16'h0005); emit(16'h0000);
        emit(16'h0006); emit(16'h0003); emit(16'h0001);
        emit(16'h0001); emit(16'h0001); dump();
        run_prog("movir_add", 0);

        pm_clear();
        emit(16'h0006); emit(16'h00A5); emit(16'h0000);
        emit(16'h0004); emit(16'h0000); emit(16'h0020);
        emit(16'h0005); emit(16'h0020); emit(16'h0002); dump();
        run_prog("mem_handshake", 3);

        pm_clear();
        emit(16'h0006); emit(16'h0004); emit(16'h0001);
        emit(16'h0008); emit(16'h0021); emit(16'h0040);
        wp = 8'h40; emit(16'h000C); emit(16'h0001); emit(16'h0050);
        emit(16'h000D); emit(16'h0001); emit(16'h0060);
        wp = 8'h60; emit(16'h0009); emit(16'h0022); emit(16'h0070); dump();
        run_prog("cond_jumps", -1);

        pm_clear();
        emit(16'h000D); emit(16'h0001); emit(16'h0020);
        emit(16'h0006); emit(16'h0001); emit(16'h0001);
        emit(16'h0007); emit(16'h00FF);
        pm_mem[8'hFF] = 16'h0000;
        wp = 8'h20; dump();
        run_prog("pc_wrap", -1);

        pm_clear();
        emit(16'h0006); emit(16'hBEEF); emit(16'h0007);
        emit(16'h0008); emit(16'h000F); emit(16'h0030);
        wp = 8'h30; dump();
        run_prog("wide_params", -1);

        for (int i = 0; i < 5; i++) begin
            pm_clear();
            emit(16'h0006); emit(16'($urandom)); emit(16'h0003);
            emit(rw(bad[i]));
            run_prog($sformatf("illegal_%02h", bad[i]), 0);
        end

        // Reset in the middle of a stalled memory write abandons the request.
        pm_clear();
        emit(16'h0006); emit(16'h1234); emit(16'h0000);
        emit(16'h0004); emit(16'h0000); emit(16'h0030);
        exp_mem_q.delete(); delay_q.delete(); exp_halt_q.delete();
        exp_mem_q.push_back('{1'b1, 8'h30, 16'h1234});
        delay_q.push_back(50);
        do_reset();
        n = 0;
        while (!dm_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!dm_req) fail("rstmem_no_req");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmem_req", dm_req, 0);
        check("rstmem_halted", halted, 0);
        $display("run rst_mid_mem: dm_req=%0b after reset", dm_req);

        for (int i = 0; i < 20; i++) begin
            gen_random();
            run_prog($sformatf("random_%0d", i), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cu_param.md
# cu_param

Parametrised successor to the 8-bit control unit. It executes the same opcode set over configurable data width, program-address width and register-file size. Compared with the 8-bit unit it adds an explicit multi-cycle FSM, a synchronous reset, a req/ack data-memory handshake in place of the bidirectional bus, and a halt on illegal opcodes. It sits between program memory, data memory and the existing combinational ALU.

## Interface
- DATA_W, 8, data, register and program-word width; legal values are 8 and 16.
- ADDR_W, 8, width of program and data addresses; must be ≤ DATA_W.
- NUM_GPR, 4, number of general-purpose registers; legal values are 2, 4 and 8. Register 0 is the accumulator.

- clk  in  1  clock; everything is rising-edge.
- rst  in  1  reset; one clock, synchronous, active-high.
- pm_addr  out  ADDR_W  program address; combinational, equal to pc.
- pm_data  in  DATA_W  program word at pm_addr; combinational read.
- dm_req  out  1  data-memory request; registered.
- dm_we  out  1  1 = write, 0 = read; valid while dm_req is high.
- dm_addr  out  ADDR_W  data-memory address.
- dm_wdata  out  DATA_W  write data.
- dm_rdata  in  DATA_W  read data; sampled on the dm_ack cycle.
- dm_ack  in  1  completes the request.
- alu_op  out  8  ALU opcode; equals the instruction opcode.
- alu_a, alu_b  out  DATA_W  ALU operands; registered.
- alu_result  in  DATA_W  combinational ALU result.
- halted  out  1  core has stopped on an illegal opcode.
- pc_dbg  out  ADDR_W  current pc.

## Operation
- **Opcodes (IR low 8 bits):**
  - NOP 00, ADD 01, SUB 02, MOVRR 03.
  - MOVRA 04 (reg→mem), MOVAR 05 (mem→reg), MOVIR 06 (imm→reg).
  - JMP 07, JB 08, JNB 09, JZ 0C, JNZ 0D.
  - CPL 0E, AND 0F, OR 10, XOR 11, CLR 12, RSH 13, LSH 14.
  - Any other value is illegal.
- **Operand fields:**
  - Destination register = op[2:0], low clog2(NUM_GPR) bits.
  - Source register = op[6:4], low clog2(NUM_GPR) bits.
  - Bit index (JB/JNB) = op[7:4], low clog2(DATA_W) bits.
  - Addresses and jump targets use the low ADDR_W bits.
- **Operand order:**
  - MOVRR: one word (src in [6:4], dst in [2:0]).
  - ADD/SUB/AND/OR/XOR: one word (register in [2:0]).
  - MOVRA: op1 = source register, op2 = address.
  - MOVAR: op1 = address, op2 = destination register.
  - MOVIR: op1 = immediate, op2 = destination register.
  - Conditional jumps: op1 = condition register/bit, op2 = target.
  - JMP: op1 = target.
- **FSM states and transitions:**
  - FETCH: IR ← pm_data, pc ← pc+1, go to DECODE.
  - DECODE:
    - NOP → FETCH.
    - CLR: r0 ← 0, → FETCH.
    - CPL/RSH/LSH: alu_op ← IR, alu_a ← r0, alu_b ← 0, → WB.
    - Illegal → HALT.
    - All others → OP1.
  - OP1: op1 ← pm_data, pc ← pc+1, then:
    - MOVRR: r[dst] ← r[src], → FETCH.
    - JMP: pc ← target, → FETCH.
    - ALU binary: alu_a ← r0, alu_b ← r[op[2:0]], → WB.
    - All others → OP2.
  - OP2: op2 ← pm_data, pc ← pc+1, then:
    - Conditional jump taken: pc ← target instead, → FETCH.
    - Conditional jump not taken: execution continues after op2.
    - MOVIR: r[dst] ← op1, → FETCH.
    - MOVRA/MOVAR: set dm_req, dm_we, dm_addr and dm_wdata, → MEM.
  - MEM:
    - Hold all dm_* outputs stable until dm_ack is sampled high.
    - On ack: clear dm_req; for MOVAR, r[dst] ← dm_rdata; → FETCH.
  - WB: r0 ← alu_result, → FETCH.
  - HALT: terminal. halted = 1, pc frozen. Only rst leaves this state.
- **Jump conditions:**
  - JB: selected bit = 1. JNB: selected bit = 0.
  - JZ: register == 0. JNZ: register ≠ 0.
- pc wraps modulo 2^ADDR_W. Data-width arithmetic is performed in the ALU; this block does not compute flags.
- dm_ack is ignored outside MEM.

## Timing
- **Reset values:**
  - pc = 0, state FETCH, all registers = 0.
  - dm_req = 0, dm_we = 0, dm_addr = 0, dm_wdata = 0.
  - alu_op = 0, alu_a = 0, alu_b = 0, halted = 0.
- **Cycles per instruction:**
  - NOP/CLR: 2.
  - CPL/RSH/LSH, MOVRR, JMP: 3.
  - ALU binary, MOVIR, conditional jumps: 4.
  - MOVRA/MOVAR: 5 + N, where N = cycles dm_ack stays low after the first MEM cycle.
- dm_req rises on the clock entering MEM and falls on the clock after dm_ack is sampled high. For back-to-back memory instructions, dm_req is low for at least 4 cycles in between.
- A register written in WB or MEM is visible to the next instruction's DECODE.
- rst mid-MEM: dm_req is 0 the following cycle and the transaction is abandoned. rst while halted clears halted.

## Test plan
- **Reset and NOP:** assert rst for 2 cycles, then run program 00 00. Expect pm_addr 0→1→2 with 2 cycles per NOP, halted = 0, all dm_*/alu_* outputs = 0.
- **MOVIR then ADD:** program 06 05 00, 06 03 01, 01 01. Expect r0 = 5, r1 = 3; alu_a = 5, alu_b = 3, alu_op = 01 in WB; with model ALU, r0 = 8. Total 12 cycles.
- **Memory handshake:** MOVRA r0 to address 0x20 with dm_ack delayed 3 cycles. Expect dm_req high for 4 cycles with dm_we = 1, dm_addr = 0x20, dm_wdata = r0 held stable. Then MOVAR 0x20 → r2 with dm_rdata = 0xA5 gives r2 = 0xA5.
- **Conditional jumps:** with r1 = 0x04, JB 21 40 jumps to pc 0x40; JZ 01 40 is not taken and falls through to pc+3; JNZ 01 50 jumps to 0x50.
- **Wrap and illegal:** JMP FF, then fetch at 0xFF followed by pc = 0x00 (ADDR_W = 8). Opcode 0x0A sets halted = 1 two cycles after its fetch and pc stays frozen for 10 cycles; rst clears halted.
- **Parameters:** with DATA_W = 16 and NUM_GPR = 8, JB 0F 30 tests bit 0 of r7; MOVIR 0xBEEF to r7 stores the full 16 bits.
